// File: rtl/spi_pwm_cfg_pkg.sv
// Shared definitions for the SPI-driven PWM configuration block: register map,
// frame layout and the frame FSM state type.
package spi_pwm_cfg_pkg;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;

  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_PWM_DUTY  = 7'h04;

  // Frame layout, MSB first on the wire: R/W, 7-bit address, 8-bit data.
  localparam int RW_BIT   = 15;
  localparam int ADDR_MSB = 14;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } frame_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] en_out_lo;
    logic [DATA_W-1:0] en_out_hi;
    logic [DATA_W-1:0] en_pwm_lo;
    logic [DATA_W-1:0] en_pwm_hi;
    logic [DATA_W-1:0] pwm_duty;
  } cfg_regs_t;

endpackage

// File: rtl/spi_pwm_cfg_ctrl_sync_edge_det.sv
// Multi-flop synchronizer for one asynchronous pin, with a history flop that
// turns the synchronized level into single-cycle rise/fall strobes.
module sync_edge_det #(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_LEVEL  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Preloading the idle level keeps reset release from looking like a pin edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
      hist_q <= IDLE_LEVEL;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous
      // stage's old value, so the chain really shifts one flop per clock.
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_pwm_cfg_ctrl.sv
// SPI mode-0 write-only target that commits 16-bit frames into the five PWM /
// output-enable configuration registers, fully oversampled in the clk domain.
module spi_pwm_cfg_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4,
  parameter int FRAME_BITS  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       txn_done,
  output logic       txn_err
);

  import spi_pwm_cfg_pkg::*;

  localparam int               CNT_W    = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

  logic sclk_level, sclk_rise, sclk_fall;
  logic copi_level, copi_rise, copi_fall;
  logic ncs_level, ncs_rise, ncs_fall;
  logic unused_sync;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(sclk),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_copi (
    .clk(clk), .rst(rst), .din(copi),
    .level(copi_level), .rise(copi_rise), .fall(copi_fall)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_sync_ncs (
    .clk(clk), .rst(rst), .din(ncs),
    .level(ncs_level), .rise(ncs_rise), .fall(ncs_fall)
  );

  // Mode 0 only needs sclk rises and the copi level; the rest is left unused.
  assign unused_sync = ^{sclk_level, sclk_fall, copi_rise, copi_fall, ncs_level};

  frame_state_e            state_q, state_d;
  logic [CNT_W-1:0]        bit_cnt_q;
  logic [FRAME_BITS-1:0]   shift_q;
  logic                    overflow_q;
  cfg_regs_t               regs_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // A frame start seen during COMMIT goes straight to SHIFT so the one-cycle
  // fall strobe is never dropped.
  always_comb begin
    // NOTE: assigning a default first guarantees every path drives state_d,
    // so no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ncs_fall) state_d = SHIFT;
      SHIFT:   if (ncs_rise) state_d = COMMIT;
      COMMIT:  state_d = ncs_fall ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ncs rise has priority: an sclk rise detected in the same cycle is not shifted.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      overflow_q <= 1'b0;
    end else if (ncs_fall && state_q != SHIFT) begin
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      overflow_q <= 1'b0;
    end else if (state_q == SHIFT && sclk_rise && !ncs_rise) begin
      if (bit_cnt_q < CNT_FULL) begin
        shift_q   <= {shift_q[FRAME_BITS-2:0], copi_level};
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end else begin
        overflow_q <= 1'b1;
      end
    end
  end

  logic [ADDR_W-1:0] frame_addr;
  logic [DATA_W-1:0] frame_data;
  logic              frame_valid;
  logic              commit_write;
  logic              commit_drop;

  always_comb begin
    frame_addr   = shift_q[ADDR_MSB:ADDR_LSB];
    frame_data   = shift_q[DATA_MSB:DATA_LSB];
    frame_valid  = (bit_cnt_q == CNT_FULL) && !overflow_q && shift_q[RW_BIT] &&
                   (frame_addr <= ADDR_W'(MAX_ADDR));
    commit_write = (state_q == COMMIT) && frame_valid;
    commit_drop  = (state_q == COMMIT) && !frame_valid && (bit_cnt_q != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the bank is five plain flops, not a RAM, so resetting it is cheap
      // and gives the PWM a defined all-off configuration.
      regs_q   <= '0;
      txn_done <= 1'b0;
      txn_err  <= 1'b0;
    end else begin
      txn_done <= commit_write;
      txn_err  <= commit_drop;
      if (commit_write) begin
        unique case (frame_addr)
          ADDR_EN_OUT_LO: regs_q.en_out_lo <= frame_data;
          ADDR_EN_OUT_HI: regs_q.en_out_hi <= frame_data;
          ADDR_EN_PWM_LO: regs_q.en_pwm_lo <= frame_data;
          ADDR_EN_PWM_HI: regs_q.en_pwm_hi <= frame_data;
          ADDR_PWM_DUTY:  regs_q.pwm_duty  <= frame_data;
          default: ;
        endcase
      end
    end
  end

  assign en_reg_out_7_0  = regs_q.en_out_lo;
  assign en_reg_out_15_8 = regs_q.en_out_hi;
  assign en_reg_pwm_7_0  = regs_q.en_pwm_lo;
  assign en_reg_pwm_15_8 = regs_q.en_pwm_hi;
  assign pwm_duty_cycle  = regs_q.pwm_duty;

endmodule

// File: tb/tb_spi_pwm_cfg_ctrl.sv
// Self-checking bench: SPI frames are bit-banged at sclk = clk/10, expected
// commits/drops are queued per frame and matched against txn_done/txn_err.
module tb_spi_pwm_cfg_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk;
  logic       copi;
  logic       ncs;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       txn_done;
  logic       txn_err;

  spi_pwm_cfg_ctrl dut (
    .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .txn_done(txn_done), .txn_err(txn_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_err;
    logic [2:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] mdl[5];
  int         n_checks  = 0;
  int         n_pass    = 0;
  int         done_seen = 0;
  int         err_seen  = 0;
  int         exp_done  = 0;
  int         exp_err   = 0;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  task automatic check_regs(input string tag);
    logic [7:0] cur[5];
    cur[0] = en_reg_out_7_0;
    cur[1] = en_reg_out_15_8;
    cur[2] = en_reg_pwm_7_0;
    cur[3] = en_reg_pwm_15_8;
    cur[4] = pwm_duty_cycle;
    for (int i = 0; i < 5; i++) check($sformatf("%s_reg%0d", tag, i), 32'(cur[i]), 32'(mdl[i]));
  endtask

  // Reference decision for a frame of nbits bits, right-aligned in bits.
  task automatic expect_frame(input logic [31:0] bits, input int nbits);
    exp_t e;
    logic [6:0] a;
    a = bits[14:8];
    e.is_err = 1'b1;
    e.addr   = '0;
    e.data   = '0;
    if (nbits == 16 && bits[15] && a <= 7'd4) begin
      e.is_err = 1'b0;
      e.addr   = a[2:0];
      e.data   = bits[7:0];
      exp_done++;
    end else begin
      exp_err++;
    end
    if (nbits > 0) sb_q.push_back(e);
  endtask

  task automatic shift_bits(input logic [31:0] bits, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      copi = bits[i];
      repeat (5) @(negedge clk);
      sclk = 1'b1;
      repeat (5) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic frame_body(input logic [31:0] bits, input int nbits);
    ncs = 1'b0;
    repeat (5) @(negedge clk);
    shift_bits(bits, nbits - 1, 0);
    repeat (5) @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] bits, input int nbits, input int gap);
    expect_frame(bits, nbits);
    frame_body(bits, nbits);
    ncs = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (sb_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(sb_q.size()), 32'd0);
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (txn_done || txn_err)) begin
        if (txn_done) done_seen++;
        if (txn_err)  err_seen++;
        if (sb_q.size() == 0) begin
          check("unexpected_pulse", {30'd0, txn_done, txn_err}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("txn_kind", {30'd0, txn_done, txn_err}, e.is_err ? 32'd1 : 32'd2);
          if (!e.is_err) mdl[e.addr] = e.data;
          check_regs("after_txn");
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 5; i++) mdl[i] = 8'h00;
    rst  = 1'b1;
    ncs  = 1'b1;
    sclk = 1'b0;
    copi = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check_regs("reset");
    check("reset_done", 32'(txn_done), 32'd0);
    check("reset_err", 32'(txn_err), 32'd0);
    repeat (100) @(negedge clk);
    check("idle_pulses", 32'(done_seen + err_seen), 32'd0);

    // First write with exact commit latency measured from the ncs rise.
    expect_frame(32'h80F0, 16);
    frame_body(32'h80F0, 16);
    ncs = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("latency_before", 32'(en_reg_out_7_0), 32'h00);
    @(posedge clk);
    #1 check("latency_after", 32'(en_reg_out_7_0), 32'hF0);
    @(negedge clk);
    repeat (10) @(negedge clk);
    drain("drain_first");

    send_frame(32'h8480, 16, 10);
    send_frame(32'h8200, 16, 10);
    drain("drain_duty");

    send_frame(32'h05AA, 16, 10);
    send_frame(32'h85AA, 16, 10);
    send_frame(32'h4055, 15, 10);
    send_frame(32'h1_0155, 17, 10);
    drain("drain_invalid");
    check("invalid_err_count", 32'(err_seen), 32'd4);
    check_regs("after_invalid");

    // Reset in the middle of a frame: the partial frame must vanish silently.
    ncs = 1'b0;
    repeat (5) @(negedge clk);
    shift_bits(32'h81FF, 15, 8);
    rst  = 1'b1;
    ncs  = 1'b1;
    sclk = 1'b0;
    for (int i = 0; i < 5; i++) mdl[i] = 8'h00;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_regs("after_abort");
    send_frame(32'h8133, 16, 10);
    drain("drain_abort");
    check("abort_no_err", 32'(err_seen), 32'd4);

    // Back-to-back frames with only two clocks of ncs high between them.
    send_frame(32'h8011, 16, 2);
    send_frame(32'h8122, 16, 10);
    drain("drain_b2b");
    check("b2b_out_lo", 32'(en_reg_out_7_0), 32'h11);
    check("b2b_out_hi", 32'(en_reg_out_15_8), 32'h22);

    check("done_count", 32'(done_seen), 32'(exp_done));
    check("err_count", 32'(err_seen), 32'(exp_err));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
